fetch_queue_unit: RTL and testbench

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

---
 rtl/fetch_queue_unit_if.sv | 39 +++
 rtl/fetch_queue_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Purpose: bundles the instruction-memory, branch-resolution and decode-side signals of the fetch unit.
// Latency: wiring only, no storage.
// Backpressure: decode applies stall_i; the memory answers with imem_data_ready_i.
interface fetch_queue_unit_if;
    logic [31:0] imem_address_o;
    logic        imem_read_o;
    logic [31:0] imem_data_i;
    logic        imem_data_ready_i;
    logic        branch_mispredicted_i;
    logic [31:0] branch_target_i;
    logic        have_branch_history_i;
    logic [31:0] branch_history_address_i;
    logic        branch_history_decision_i;
    logic        stall_i;
    logic        instruction_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        branch_predicted_o;

    // Fetch unit side
    modport master (
        output imem_address_o, imem_read_o,
        output instruction_valid_o, instruction_o, pc_o, branch_predicted_o,
        input  imem_data_i, imem_data_ready_i,
        input  branch_mispredicted_i, branch_target_i,
        input  have_branch_history_i, branch_history_address_i, branch_history_decision_i,
        input  stall_i
    );

    // Memory / pipeline side
    modport slave (
        input  imem_address_o, imem_read_o,
        input  instruction_valid_o, instruction_o, pc_o, branch_predicted_o,
        output imem_data_i, imem_data_ready_i,
        output branch_mispredicted_i, branch_target_i,
        output have_branch_history_i, branch_history_address_i, branch_history_decision_i,
        output stall_i
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Purpose: instruction fetch with one outstanding request, predecode, 2-bit BHT prediction and a small queue.
// Latency: a returned word is visible at the queue head one cycle after imem_data_ready_i.
// Backpressure: stall_i holds the head; new requests stop once the queue has no room for their word.
module fetch_queue_unit #(
    parameter int          QUEUE_DEPTH    = 4,
    parameter int          BHT_INDEX_BITS = 6,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input logic           clock_i,
    input logic           reset_n_i,
    fetch_queue_unit_if.master fq
);
    localparam int PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic             pending_q, pending_d;
    logic             discard_q, discard_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, count_after;
    entry_t           queue_q [QUEUE_DEPTH];
    logic [1:0]       bht_q [BHT_ENTRIES];

    logic        complete, accept, deq, read;
    logic [31:0] word, rel_tgt, jmp_tgt, next_addr;
    logic        is_uncond, is_cond, is_jump, pred_taken;
    logic [BHT_INDEX_BITS-1:0] look_idx, upd_idx;
    logic        unused_hist_bits;
    entry_t      head_entry, new_entry;

    // A word belongs to the in-flight request only when one is pending; a word for a
    // request issued before a flush is thrown away via discard_q.
    assign complete = pending_q & fq.imem_data_ready_i;
    assign accept   = complete & ~discard_q & ~fq.branch_mispredicted_i;
    assign word     = fq.imem_data_i;

    assign is_uncond  = (word[31:26] == 6'b000001) && (word[25:21] == 5'd31) && (word[20:16] == 5'd31);
    assign is_cond    = (word[31:27] == 5'b11000);
    assign is_jump    = (word[31:27] == 5'b11001);
    assign rel_tgt    = pend_addr_q + 32'd4 + {{16{word[15]}}, word[15:0]};
    assign jmp_tgt    = {6'b0, word[25:0]};
    assign look_idx   = pend_addr_q[BHT_INDEX_BITS+1:2];
    assign pred_taken = is_uncond | is_jump | (is_cond & bht_q[look_idx][1]);

    assign next_addr = !accept    ? fetch_pc_q :
                       pred_taken ? (is_jump ? jmp_tgt : rel_tgt) :
                                    pend_addr_q + 32'd4;

    assign deq         = (count_q != '0) & ~fq.stall_i;
    assign count_after = count_q + CNT_W'(accept) - CNT_W'(deq);

    // The single outstanding request may be reissued in the cycle its word returns,
    // provided the queue will still have a free slot for the new word.
    assign read = reset_n_i & ~fq.branch_mispredicted_i & (~pending_q | complete)
                & (count_after < CNT_W'(QUEUE_DEPTH));

    assign fq.imem_read_o    = read;
    assign fq.imem_address_o = next_addr;

    assign new_entry  = '{word: word, pc: pend_addr_q + 32'd4, pred: pred_taken};
    assign head_entry = queue_q[head_q];

    assign fq.instruction_valid_o = (count_q != '0);
    assign fq.instruction_o       = fq.instruction_valid_o ? head_entry.word : 32'h0;
    assign fq.pc_o                = fq.instruction_valid_o ? head_entry.pc   : 32'h0;
    assign fq.branch_predicted_o  = fq.instruction_valid_o & head_entry.pred;

    assign upd_idx          = fq.branch_history_address_i[BHT_INDEX_BITS+1:2];
    assign unused_hist_bits = ^{fq.branch_history_address_i[31:BHT_INDEX_BITS+2],
                                fq.branch_history_address_i[1:0]};

    // Next-state for fetch control and queue pointers; a flush overrides enqueue/dequeue.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pend_addr_d = pend_addr_q;
        pending_d   = pending_q;
        discard_d   = discard_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (fq.branch_mispredicted_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = fq.branch_target_i;
            pending_d  = pending_q & ~fq.imem_data_ready_i;
            discard_d  = pending_q & ~fq.imem_data_ready_i;
        end else begin
            fetch_pc_d = next_addr;
            if (read) begin
                pending_d   = 1'b1;
                pend_addr_d = next_addr;
            end else if (complete) begin
                pending_d = 1'b0;
            end
            if (complete) discard_d = 1'b0;
            if (accept)   tail_d    = tail_q + PTR_W'(1);
            if (deq)      head_d    = head_q + PTR_W'(1);
            count_d = count_after;
        end
    end

    // Control state register with synchronous reset that abandons any request in flight.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            fetch_pc_q  <= RESET_PC;
            pend_addr_q <= RESET_PC;
            pending_q   <= 1'b0;
            discard_q   <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_addr_q <= pend_addr_d;
            pending_q   <= pending_d;
            discard_q   <= discard_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Queue storage: write the accepted word at the tail; contents are don't-care while empty.
    always_ff @(posedge clock_i) begin
        if (reset_n_i && accept) queue_q[tail_q] <= new_entry;
    end

    // Branch history counters; a same-cycle lookup above reads the old value.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (fq.have_branch_history_i) begin
            if (fq.branch_history_decision_i && bht_q[upd_idx] != 2'b11)
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            else if (!fq.branch_history_decision_i && bht_q[upd_idx] != 2'b00)
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
    localparam int          DEPTH    = 4;
    localparam int          BHT_BITS = 6;
    localparam logic [31:0] RST_PC   = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_queue_unit_if bus();

    fetch_queue_unit #(.QUEUE_DEPTH(DEPTH), .BHT_INDEX_BITS(BHT_BITS), .RESET_PC(RST_PC)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .fq        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    exp_t        sb[$];
    logic [31:0] model_pc    = RST_PC;
    bit          outstanding = 0;
    bit          discard     = 0;
    logic [31:0] req_addr    = 0;
    int          delay       = 0;
    int          bht_m[1 << BHT_BITS];
    logic [31:0] mem_ovr[bit [31:0]];
    logic [31:0] read_log[$];

    // stimulus knobs
    bit          rst_val = 0;
    bit          spurious = 0;
    bit          mode_rand = 0;
    int          p_stall = 0, p_mis = 0, p_hist = 0;
    int          min_delay = 0, max_delay = 0;
    bit          force_stall = 0, stall_val = 0;
    bit          force_mis = 0;
    logic [31:0] force_tgt = 0;
    bit          force_hist = 0, force_hd = 0;
    logic [31:0] force_ha = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Program image: straight-line filler, or a hashed mix of branches and filler.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [15:0] imm;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        if (!mode_rand) return 32'h5400_0000;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        imm = {{8{h[9]}}, h[9:4], 2'b00};
        case (h[3:0])
            4'd0:             return {6'b000001, 5'd31, 5'd31, imm};
            4'd1, 4'd2, 4'd3: return {5'b11000, h[26:16], imm};
            4'd4:             return {5'b11001, 1'b0, 16'h0, h[13:6], 2'b00};
            default:          return {6'b010101, h[31:6]};
        endcase
    endfunction

    // Architectural next-PC rule for a word fetched at address a.
    task automatic predict(input logic [31:0] w, input logic [31:0] a, output logic tk, output logic [31:0] nxt);
        logic [31:0] rel;
        rel = a + 32'd4 + {{16{w[15]}}, w[15:0]};
        tk  = 1'b0;
        nxt = a + 32'd4;
        if (w[31:26] == 6'b000001 && w[25:21] == 5'd31 && w[20:16] == 5'd31) begin
            tk = 1'b1; nxt = rel;
        end else if (w[31:27] == 5'b11000) begin
            tk = (bht_m[a[BHT_BITS+1:2]] >= 2);
            if (tk) nxt = rel;
        end else if (w[31:27] == 5'b11001) begin
            tk = 1'b1; nxt = {6'b0, w[25:0]};
        end
    endtask

    // One clock of stimulus, memory response and model update.
    task automatic cycle();
        logic        stall, mis, hv, hd, rdy, exp_read, tk;
        logic [31:0] tgt, ha, data, nxt;
        int          deq_n, cnt;
        exp_t        e;
        @(negedge clk);
        rst_n = rst_val;
        stall = force_stall ? stall_val : ($urandom_range(0, 99) < p_stall);
        mis   = force_mis || (rst_val && ($urandom_range(0, 99) < p_mis));
        tgt   = force_mis ? force_tgt : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        force_mis = 0;
        if (force_hist) begin
            hv = 1'b1; ha = force_ha; hd = force_hd; force_hist = 0;
        end else begin
            hv = ($urandom_range(0, 99) < p_hist);
            ha = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            hd = 1'($urandom_range(0, 1));
        end
        rdy = 1'b0;
        if (outstanding) begin
            if (delay == 0) rdy = 1'b1; else delay--;
        end else if (spurious) begin
            rdy = 1'b1;
        end
        spurious = 0;
        data = rdy ? (outstanding ? mem_word(req_addr) : 32'hDEAD_BEEF) : $urandom;

        bus.stall_i                   = stall;
        bus.branch_mispredicted_i     = mis;
        bus.branch_target_i           = tgt;
        bus.have_branch_history_i     = hv;
        bus.branch_history_address_i  = ha;
        bus.branch_history_decision_i = hd;
        bus.imem_data_ready_i         = rdy;
        bus.imem_data_i               = data;

        if (!rst_val) begin
            sb.delete();
            outstanding = 0;
            discard     = 0;
            foreach (bht_m[i]) bht_m[i] = 1;
            model_pc = RST_PC;
            exp_read = 1'b0;
        end else begin
            deq_n = (sb.size() > 0 && !stall && !mis) ? 1 : 0;
            if (mis) begin
                discard = outstanding && !rdy;
                if (rdy) outstanding = 0;
                sb.delete();
                model_pc = tgt;
                exp_read = 1'b0;
            end else begin
                if (outstanding && rdy) begin
                    outstanding = 0;
                    if (discard) begin
                        discard = 0;
                    end else begin
                        predict(data, req_addr, tk, nxt);
                        e.word = data; e.pc = req_addr + 32'd4; e.pred = tk;
                        sb.push_back(e);
                        model_pc = nxt;
                    end
                end
                cnt = sb.size() - deq_n;
                exp_read = !outstanding && (cnt < DEPTH);
            end
            if (hv) begin
                if (hd) bht_m[ha[BHT_BITS+1:2]] = (bht_m[ha[BHT_BITS+1:2]] == 3) ? 3 : bht_m[ha[BHT_BITS+1:2]] + 1;
                else    bht_m[ha[BHT_BITS+1:2]] = (bht_m[ha[BHT_BITS+1:2]] == 0) ? 0 : bht_m[ha[BHT_BITS+1:2]] - 1;
            end
        end

        #1;
        check("imem_read_o", {31'd0, bus.imem_read_o}, {31'd0, exp_read});
        if (bus.imem_read_o) begin
            read_log.push_back(bus.imem_address_o);
            if (exp_read) check("imem_address_o", bus.imem_address_o, model_pc);
            req_addr    = exp_read ? model_pc : bus.imem_address_o;
            outstanding = 1;
            delay       = $urandom_range(min_delay, max_delay);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_val = 0;
        run(2);
        rst_val  = 1;
        spurious = 1;
        read_log.delete();
    endtask

    task automatic hist(input logic [31:0] a, input bit d);
        force_hist = 1; force_ha = a; force_hd = d;
        cycle();
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands an instruction to decode.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.instruction_valid_o) begin
                    if (!bus.stall_i && !bus.branch_mispredicted_i) begin
                        n_checks++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL dequeue_unexpected: got pc_o %h expected no instruction", bus.pc_o);
                        end else begin
                            e = sb.pop_front();
                            check("instruction_o", bus.instruction_o, e.word);
                            check("pc_o", bus.pc_o, e.pc);
                            check("branch_predicted_o", {31'd0, bus.branch_predicted_o}, {31'd0, e.pred});
                        end
                    end
                end else begin
                    check("idle_instruction_o", bus.instruction_o, 32'h0);
                    check("idle_pc_o", bus.pc_o, 32'h0);
                    check("idle_branch_predicted_o", {31'd0, bus.branch_predicted_o}, 32'h0);
                end
            end
        end
    end

    initial begin
        foreach (bht_m[i]) bht_m[i] = 1;
        bus.stall_i = 0; bus.branch_mispredicted_i = 0; bus.branch_target_i = 0;
        bus.have_branch_history_i = 0; bus.branch_history_address_i = 0;
        bus.branch_history_decision_i = 0; bus.imem_data_ready_i = 0; bus.imem_data_i = 0;

        // Straight-line code, single-cycle memory, no stalls: no bubbles.
        do_reset();
        run(20);
        check("straight_read_count", read_log.size(), 20);
        check("straight_addr5", read_log[5], 32'h14);

        // Unconditional branch to itself at 0x10.
        mem_ovr[32'h10] = 32'h07FF_FFFC;
        do_reset();
        run(10);
        check("uncond_addr_after", read_log[5], 32'h10);
        check("uncond_addr_again", read_log[6], 32'h10);
        mem_ovr.delete(32'h10);

        // Decode stalled: the queue fills to depth and fetching stops.
        do_reset();
        force_stall = 1; stall_val = 1;
        run(15);
        check("stall_reads", read_log.size(), DEPTH);
        check("stall_read_idle", {31'd0, bus.imem_read_o}, 32'h0);
        force_stall = 0;
        run(10);

        // Mispredict while a slow request is pending: its word is dropped.
        do_reset();
        min_delay = 3; max_delay = 3;
        for (int i = 0; i < 10 && !outstanding; i++) cycle();
        force_mis = 1; force_tgt = 32'h100;
        read_log.delete();
        cycle();
        cycle();
        check("flush_empty", {31'd0, bus.instruction_valid_o}, 32'h0);
        check("flush_wait", {31'd0, bus.imem_read_o}, 32'h0);
        run(10);
        check("flush_redirect", read_log[0], 32'h100);
        min_delay = 0; max_delay = 0;

        // Conditional branch at 0x20 trained taken, then back to weakly not taken.
        mem_ovr[32'h20] = 32'hC000_0040;
        do_reset();
        hist(32'h20, 1); hist(32'h20, 1); hist(32'h20, 1);
        run(12);
        check("bht_taken_target", read_log[9], 32'h64);
        hist(32'h20, 0); hist(32'h20, 0);
        force_mis = 1; force_tgt = 32'h20;
        cycle();
        read_log.delete();
        run(4);
        check("bht_refetch", read_log[0], 32'h20);
        check("bht_not_taken", read_log[1], 32'h24);

        // Reset with two entries queued and a request pending.
        do_reset();
        force_stall = 1; stall_val = 1;
        run(3);
        do_reset();
        force_stall = 0;
        cycle();
        check("rst_valid", {31'd0, bus.instruction_valid_o}, 32'h0);
        check("rst_instr", bus.instruction_o, 32'h0);
        check("rst_pc", bus.pc_o, 32'h0);
        check("rst_pred", {31'd0, bus.branch_predicted_o}, 32'h0);
        check("rst_first_fetch", read_log[0], RST_PC);

        // Randomised traffic over a branchy program.
        mode_rand = 1;
        p_stall = 30; p_mis = 3; p_hist = 25;
        min_delay = 0; max_delay = 3;
        run(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
